// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the stack_lifo_p LIFO stack.
//   op_e        - per-cycle request decode produced by the top level
//   cnt_width() - width needed to hold an occupancy of 0..depth
//   addr_width()- width needed to address depth storage entries
package stack_pkg;

   typedef enum logic [2:0] {
      OP_IDLE   = 3'd0,  // no request
      OP_PUSH   = 3'd1,  // push into a non-full stack
      OP_POP    = 3'd2,  // pop from a non-empty stack
      OP_SWAP   = 3'd3,  // push+pop on a non-empty stack: replace top
      OP_BYPASS = 3'd4,  // push+pop on an empty stack: d_in goes straight out
      OP_DROP   = 3'd5,  // push into a full stack, word discarded
      OP_UNDER  = 3'd6   // pop from an empty stack
   } op_e;

   // Occupancy runs 0..depth inclusive, hence depth+1 states.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x DATA_W register file backing the stack.
//   i_clk    clock, write on rising edge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  asynchronous read address
//   o_rdata  asynchronous read data
// Contents are not reset; the top level never reads an entry it has not written.
module stack_mem
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned AW    = addr_width(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_lifo_p.sv
// stack_lifo_p: parametrised LIFO stack with simultaneous push+pop.
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   i_push         push request
//   i_pop          pop request
//   i_clear        synchronous flush of all entries and error flags
//   i_d_in         data to push
//   o_d_out        registered pop data, holds last popped value
//   o_d_valid      one-cycle strobe: o_d_out updated this cycle
//   o_peek         current top entry, 0 when empty
//   o_count        entries held, 0..DEPTH
//   o_full         count == DEPTH
//   o_almost_full  count >= AF_LEVEL
//   o_empty        count == 0
//   o_overflow     sticky: a push was dropped
//   o_underflow    sticky: a pop found no data
// The top entry lives at index count-1; a push writes index count.
module stack_lifo_p
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   localparam int unsigned CNT_W   = cnt_width(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_d_in,
   output logic [DATA_W-1:0] o_d_out,
   output logic              o_d_valid,
   output logic [DATA_W-1:0] o_peek,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_almost_full,
   output logic              o_empty,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int unsigned AW = addr_width(DEPTH);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

   // Registered state
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_d_out;
   logic              r_d_valid;
   logic              r_overflow;
   logic              r_underflow;

   // Next-state and decode
   logic [CNT_W-1:0]  w_count_d;
   logic [DATA_W-1:0] w_d_out_d;
   logic              w_d_valid_d;
   logic              w_overflow_d;
   logic              w_underflow_d;
   op_e               w_op;

   logic              w_full;
   logic              w_empty;
   logic [AW-1:0]     w_top_addr;
   logic [AW-1:0]     w_push_addr;
   logic [DATA_W-1:0] w_top;
   logic              w_we;
   logic              w_we_req;
   logic [AW-1:0]     w_waddr;

   // Status decodes straight from the count register.
   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);

   // When empty the read address is parked at 0; peek is masked below.
   assign w_top_addr  = w_empty ? '0 : AW'(r_count - CNT_ONE);
   assign w_push_addr = w_full ? '0 : AW'(r_count);

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (i_d_in),
      .i_raddr (w_top_addr),
      .o_rdata (w_top)
   );

   // Request decode against current occupancy.
   always_comb begin
      w_op = OP_IDLE;
      unique case ({i_push, i_pop})
         2'b10:   w_op = w_full  ? OP_DROP   : OP_PUSH;
         2'b01:   w_op = w_empty ? OP_UNDER  : OP_POP;
         2'b11:   w_op = w_empty ? OP_BYPASS : OP_SWAP;
         default: w_op = OP_IDLE;
      endcase
   end

   // Next-state: clear overrides the decoded request.
   always_comb begin
      w_count_d     = r_count;
      w_d_out_d     = r_d_out;
      w_d_valid_d   = 1'b0;
      w_overflow_d  = r_overflow;
      w_underflow_d = r_underflow;
      w_we_req      = 1'b0;
      w_waddr       = w_push_addr;

      if (i_clear) begin
         w_count_d     = '0;
         w_overflow_d  = 1'b0;
         w_underflow_d = 1'b0;
      end else begin
         unique case (w_op)
            OP_PUSH: begin
               w_we_req  = 1'b1;
               w_count_d = r_count + CNT_ONE;
            end
            OP_DROP: begin
               w_overflow_d = 1'b1;
            end
            OP_POP: begin
               w_d_out_d   = w_top;
               w_d_valid_d = 1'b1;
               w_count_d   = r_count - CNT_ONE;
            end
            OP_UNDER: begin
               w_underflow_d = 1'b1;
            end
            OP_SWAP: begin
               // Old top leaves on d_out while the same slot takes d_in.
               w_d_out_d   = w_top;
               w_d_valid_d = 1'b1;
               w_we_req    = 1'b1;
               w_waddr     = w_top_addr;
            end
            OP_BYPASS: begin
               w_d_out_d   = i_d_in;
               w_d_valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A request in the reset cycle must not touch memory either.
   assign w_we = w_we_req & ~i_rst;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count     <= '0;
         r_d_out     <= '0;
         r_d_valid   <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_d;
         r_d_out     <= w_d_out_d;
         r_d_valid   <= w_d_valid_d;
         r_overflow  <= w_overflow_d;
         r_underflow <= w_underflow_d;
      end
   end

   assign o_d_out       = r_d_out;
   assign o_d_valid     = r_d_valid;
   assign o_peek        = w_empty ? '0 : w_top;
   assign o_count       = r_count;
   assign o_full        = w_full;
   assign o_almost_full = (r_count >= CNT_AF);
   assign o_empty       = w_empty;
   assign o_overflow    = r_overflow;
   assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_stack_lifo_p.sv
// Directed self-checking bench for stack_lifo_p (DEPTH=5, DATA_W=8, AF_LEVEL=3).
module tb_stack_lifo_p;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 5;
   localparam int unsigned CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic              clear = 1'b0;
   logic [DATA_W-1:0] d_in = '0;
   logic [DATA_W-1:0] d_out;
   logic              d_valid;
   logic [DATA_W-1:0] peek;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              almost_full;
   logic              empty;
   logic              overflow;
   logic              underflow;

   int n_checks = 0;
   int n_errors = 0;

   stack_lifo_p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_push        (push),
      .i_pop         (pop),
      .i_clear       (clear),
      .i_d_in        (d_in),
      .o_d_out       (d_out),
      .o_d_valid     (d_valid),
      .o_peek        (peek),
      .o_count       (count),
      .o_full        (full),
      .o_almost_full (almost_full),
      .o_empty       (empty),
      .o_overflow    (overflow),
      .o_underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p_push, input logic p_pop, input logic [7:0] p_d);
      push = p_push;
      pop  = p_pop;
      d_in = p_d;
   endtask

   initial begin
      logic [7:0] fill_v [5];
      logic [7:0] pop_exp [3];
      fill_v  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      pop_exp = '{8'h33, 8'h22, 8'h11};

      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_count", 32'(count), 0);
      check_eq("rst_empty", 32'(empty), 1);
      check_eq("rst_full", 32'(full), 0);
      check_eq("rst_dout", 32'(d_out), 0);
      check_eq("rst_dvalid", 32'(d_valid), 0);
      check_eq("rst_ovf", 32'(overflow), 0);
      check_eq("rst_udf", 32'(underflow), 0);
      check_eq("rst_peek", 32'(peek), 0);

      // Three pushes then three back-to-back pops
      drive(1'b1, 1'b0, 8'h11); tick();
      check_eq("push1_peek", 32'(peek), 32'h11);
      drive(1'b1, 1'b0, 8'h22); tick();
      drive(1'b1, 1'b0, 8'h33); tick();
      drive(1'b0, 1'b0, 8'h00);
      check_eq("push3_count", 32'(count), 3);
      check_eq("push3_peek", 32'(peek), 32'h33);
      check_eq("push3_af", 32'(almost_full), 1);
      check_eq("push3_full", 32'(full), 0);
      pop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("pop_dout", 32'(d_out), 32'(pop_exp[i]));
         check_eq("pop_dvalid", 32'(d_valid), 1);
         check_eq("pop_count", 32'(count), 32'(2 - i));
      end
      pop = 1'b0;
      tick();
      check_eq("pops_empty", 32'(empty), 1);
      check_eq("pops_dvalid_lo", 32'(d_valid), 0);
      check_eq("pops_dout_hold", 32'(d_out), 32'h11);

      // Underflow, sticky, then clear
      pop = 1'b1; tick(); pop = 1'b0;
      check_eq("udf_flag", 32'(underflow), 1);
      check_eq("udf_dvalid", 32'(d_valid), 0);
      check_eq("udf_dout", 32'(d_out), 32'h11);
      check_eq("udf_count", 32'(count), 0);
      tick();
      check_eq("udf_sticky", 32'(underflow), 1);
      clear = 1'b1; tick(); clear = 1'b0;
      check_eq("clr_udf", 32'(underflow), 0);
      check_eq("clr_ovf", 32'(overflow), 0);

      // Fill to full, watching almost_full
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, fill_v[i]); tick();
         check_eq("fill_count", 32'(count), 32'(i + 1));
         check_eq("fill_af", 32'(almost_full), 32'((i + 1) >= 3));
         check_eq("fill_full", 32'(full), 32'(i == 4));
      end
      drive(1'b1, 1'b0, 8'hAA); tick();
      check_eq("ovf_count", 32'(count), 5);
      check_eq("ovf_flag", 32'(overflow), 1);
      check_eq("ovf_peek", 32'(peek), 32'hA5);

      // Swap while full
      drive(1'b1, 1'b1, 8'h77); tick();
      drive(1'b0, 1'b0, 8'h00);
      check_eq("fswap_dout", 32'(d_out), 32'hA5);
      check_eq("fswap_dvalid", 32'(d_valid), 1);
      check_eq("fswap_count", 32'(count), 5);
      check_eq("fswap_peek", 32'(peek), 32'h77);
      check_eq("fswap_ovf_sticky", 32'(overflow), 1);

      // Clear with a same-cycle push: push ignored, d_out held
      clear = 1'b1;
      drive(1'b1, 1'b0, 8'h99); tick();
      clear = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      check_eq("clr_count", 32'(count), 0);
      check_eq("clr_empty", 32'(empty), 1);
      check_eq("clr_ovf2", 32'(overflow), 0);
      check_eq("clr_dvalid", 32'(d_valid), 0);
      check_eq("clr_dout_hold", 32'(d_out), 32'hA5);

      // Swap on 0x01,0x02
      drive(1'b1, 1'b0, 8'h01); tick();
      drive(1'b1, 1'b0, 8'h02); tick();
      drive(1'b1, 1'b1, 8'h77); tick();
      drive(1'b0, 1'b0, 8'h00);
      check_eq("swap_dout", 32'(d_out), 32'h02);
      check_eq("swap_dvalid", 32'(d_valid), 1);
      check_eq("swap_count", 32'(count), 2);
      check_eq("swap_peek", 32'(peek), 32'h77);
      check_eq("swap_ovf", 32'(overflow), 0);
      check_eq("swap_udf", 32'(underflow), 0);
      pop = 1'b1; tick();
      check_eq("swap_pop1", 32'(d_out), 32'h77);
      tick(); pop = 1'b0;
      check_eq("swap_pop2", 32'(d_out), 32'h01);
      check_eq("swap_empty", 32'(empty), 1);

      // Bypass on empty
      drive(1'b1, 1'b1, 8'h5C); tick();
      drive(1'b0, 1'b0, 8'h00);
      check_eq("byp_dout", 32'(d_out), 32'h5C);
      check_eq("byp_dvalid", 32'(d_valid), 1);
      check_eq("byp_count", 32'(count), 0);
      check_eq("byp_peek", 32'(peek), 0);
      check_eq("byp_ovf", 32'(overflow), 0);
      check_eq("byp_udf", 32'(underflow), 0);

      // Set underflow, fill 4, then reset together with push
      pop = 1'b1; tick(); pop = 1'b0;
      check_eq("pre_rst_udf", 32'(underflow), 1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, fill_v[i]); tick();
      end
      check_eq("pre_rst_count", 32'(count), 4);
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'hEE); tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      check_eq("mrst_count", 32'(count), 0);
      check_eq("mrst_dout", 32'(d_out), 0);
      check_eq("mrst_dvalid", 32'(d_valid), 0);
      check_eq("mrst_ovf", 32'(overflow), 0);
      check_eq("mrst_udf", 32'(underflow), 0);
      check_eq("mrst_empty", 32'(empty), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
